ren_dispatch: RTL and testbench
===============================

Name: ren_dispatch

Overview:
Rename-side dispatch stage and the transmitting end of the REN→ISS push interface. It buffers renamed instructions in a small in-order FIFO and steers each one to the IQ or the LSQ push port according to its MemRead/MemWrite bits. It honours the IQ_full/LSQ_full backpressure from ISS and stalls Rename when its own buffer fills. It sits between the rename logic and the ISS block.

Parameters:
RENISS_WIDTH, 151, width of a renamed-instruction word (same layout ISS consumes).
ADDR_WIDTH, 2, log2 of buffer depth (default depth 4).
MEMREAD_BIT, 39, bit index of MemRead in the word.
MEMWRITE_BIT, 40, bit index of MemWrite in the word.
CNT_WIDTH, 16, width of the dispatch performance counters.

Ports:
CLK  in  1  clock.
RESET  in  1  synchronous reset, active-low.
FREEZE  in  1  global pipeline freeze; blocks enqueue and dispatch.
FLUSH_IN  in  1  discard all buffered instructions.
ren_valid_IN  in  1  Rename presents an instruction.
ren_data_IN  in  RENISS_WIDTH  renamed instruction word.
ren_stall_OUT  out  1  buffer full; Rename must hold.
IQ_pushReq_OUT  out  1  push to IQ this cycle.
IQ_pushData_OUT  out  RENISS_WIDTH  IQ push word.
IQ_full_IN  in  1  IQ cannot accept.
LSQ_pushReq_OUT  out  1  push to LSQ this cycle.
LSQ_pushData_OUT  out  RENISS_WIDTH  LSQ push word.
LSQ_full_IN  in  1  LSQ cannot accept.
occupancy_OUT  out  ADDR_WIDTH+1  entries held.
iq_disp_cnt_OUT  out  CNT_WIDTH  IQ pushes since reset.
lsq_disp_cnt_OUT  out  CNT_WIDTH  LSQ pushes since reset.

Behaviour:
- Reset (RESET==0 at posedge): head, tail and occupancy go to 0; both counters go to 0. With the buffer empty, ren_stall_OUT=0, both pushReq=0 and both pushData=0.
- Storage: circular buffer of 2^ADDR_WIDTH entries. Head and tail pointers are ADDR_WIDTH bits and wrap modulo depth. occupancy is a registered value from 0 to 2^ADDR_WIDTH.
- ren_stall_OUT = (occupancy == depth). It is registered state, with no combinational path from the full inputs.
- Enqueue occurs at the posedge when ren_valid_IN && !ren_stall_OUT && !FREEZE && !FLUSH_IN. The word is written at tail and tail increments.
  - When the buffer is full, enqueue is refused even if a dispatch occurs in the same cycle. There is no same-cycle slot reuse.
- Steering is combinational from the head entry:
  - is_mem = head[MEMREAD_BIT] | head[MEMWRITE_BIT]. If both bits are set, the entry goes to the LSQ.
- Push outputs:
  - LSQ_pushReq_OUT = !empty && !FREEZE && !FLUSH_IN && is_mem && !LSQ_full_IN.
  - IQ_pushReq_OUT = !empty && !FREEZE && !FLUSH_IN && !is_mem && !IQ_full_IN.
  - At most one pushReq is high per cycle.
  - Each pushData equals the head word when its pushReq is high, else 0.
- Dispatch (pop): at the posedge where either pushReq is high, head increments and the matching counter increments. Counters wrap at 2^CNT_WIDTH.
- Ordering: strict in-order dispatch.
  - If the head's target queue is full, the head blocks, even when the other queue has space (head-of-line blocking is required).
- Latency: an instruction enqueued at edge t can be pushed no earlier than cycle t+1. There is no input-to-output bypass.
- Simultaneous enqueue and dispatch: occupancy is unchanged; both pointers advance.
- FLUSH_IN: at the posedge, head, tail and occupancy go to 0. FLUSH_IN takes priority over enqueue and dispatch. Counters are not cleared.
- FREEZE: holds all state, including the counters. Push outputs are forced low.
- Reset asserted mid-operation overrides FLUSH_IN, FREEZE and any enqueue or dispatch. All buffered entries are lost.
- Data words pass through unmodified. Busy-bit handling, ready bits and the IQ/LSQ field repacking all stay in ISS.

Decomposition:
- Shared package holds:
  - the REN→ISS word field indices (MEMREAD_BIT 39, MEMWRITE_BIT 40, NEED_DEST_BIT 149, IMM_SRC_BIT 150, SRC1 98:93, SRC2 104:99, DEST 92:87, ROB 110:105);
  - RENISS_WIDTH;
  - the IQ/LSQ target select encoding.
- One sub-module is natural: ren_dispatch_fifo.
  - Provides storage, pointers, occupancy and flush, with a combinational head read.
  - The top level adds steering, the push/full handshake and the counters.

Test Plan:
- Reset then idle: hold RESET=0 for 2 cycles, release → occupancy=0, ren_stall_OUT=0, both pushReq=0, both pushData=0, counters=0.
- Steering: enqueue an ALU op (bits 40:39=00), a load (01) and a store (10), with both full inputs low → IQ push at cycle 1, LSQ pushes at cycles 2 and 3; iq_disp_cnt=1, lsq_disp_cnt=2; data matches input.
- Head-of-line blocking: LSQ_full_IN=1 with a load at head and an ALU op behind it → no push for 5 cycles, occupancy=2; drop LSQ_full_IN → LSQ push, then IQ push on the next cycle.
- Fill and wrap: hold both full inputs high and enqueue 5 ops → 4 accepted, ren_stall_OUT=1, 5th held by Rename. Release the full inputs → 4 pushes in order. Then repeat 6 more ops → correct order after pointer wrap.
- Flush during simultaneous traffic: occupancy=3 with an enqueue and a dispatch pending, assert FLUSH_IN for one cycle → next cycle occupancy=0, no push in the flush cycle, counters unchanged.
- FREEZE: at occupancy=2, hold FREEZE for 3 cycles with ren_valid_IN=1 → no enqueue, no push, state unchanged; dispatch resumes the cycle FREEZE drops.

Source files
------------

// File: rtl/ren_dispatch_pkg.sv
// ren_dispatch_pkg: REN->ISS word layout and dispatch target encoding shared by the dispatch stage.
package ren_dispatch_pkg;
   localparam int RENISS_WIDTH  = 151;
   localparam int MEMREAD_BIT   = 39;
   localparam int MEMWRITE_BIT  = 40;
   localparam int NEED_DEST_BIT = 149;
   localparam int IMM_SRC_BIT   = 150;
   localparam int SRC1_MSB      = 98;
   localparam int SRC1_LSB      = 93;
   localparam int SRC2_MSB      = 104;
   localparam int SRC2_LSB      = 99;
   localparam int DEST_MSB      = 92;
   localparam int DEST_LSB      = 87;
   localparam int ROB_MSB       = 110;
   localparam int ROB_LSB       = 105;

   typedef enum logic {
      TGT_IQ  = 1'b0,
      TGT_LSQ = 1'b1
   } tgt_e;

   // Any memory access, including read-modify-write, belongs to the LSQ.
   function automatic tgt_e tgt_sel(input logic mem_rd, input logic mem_wr);
      return (mem_rd | mem_wr) ? TGT_LSQ : TGT_IQ;
   endfunction
endpackage

// File: rtl/ren_dispatch_fifo.sv
// ren_dispatch_fifo: in-order circular buffer with flush and a combinational head read.
module ren_dispatch_fifo
   import ren_dispatch_pkg::*;
#(
   parameter int W  = ren_dispatch_pkg::RENISS_WIDTH,
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          wr_en,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   output logic [W-1:0]  head_data,
   output logic [AW:0]   occupancy,
   output logic          full,
   output logic          empty
);
   localparam int DEPTH = 1 << AW;

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] head_q, head_d, tail_q, tail_d;
   logic [AW:0]   occ_q, occ_d;

   // Callers never write when full nor read when empty, so occupancy cannot over/underflow.
   always_comb begin
      mem_d  = mem_q;
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      if (flush) begin
         head_d = '0;
         tail_d = '0;
         occ_d  = '0;
      end else begin
         if (wr_en) begin
            mem_d[tail_q] = wr_data;
            tail_d        = tail_q + 1'b1;
         end
         if (rd_en) head_d = head_q + 1'b1;
         occ_d = occ_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   always_ff @(posedge clk) mem_q <= mem_d;

   assign head_data = mem_q[head_q];
   assign occupancy = occ_q;
   assign full      = (occ_q == (AW+1)'(DEPTH));
   assign empty     = (occ_q == '0);
endmodule

// File: rtl/ren_dispatch.sv
// ren_dispatch: buffers renamed instructions and pushes them in order to the IQ or LSQ.
module ren_dispatch
   import ren_dispatch_pkg::*;
#(
   parameter int RENISS_WIDTH = ren_dispatch_pkg::RENISS_WIDTH,
   parameter int ADDR_WIDTH   = 2,
   parameter int MEMREAD_BIT  = ren_dispatch_pkg::MEMREAD_BIT,
   parameter int MEMWRITE_BIT = ren_dispatch_pkg::MEMWRITE_BIT,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    FREEZE,
   input  logic                    FLUSH_IN,
   input  logic                    ren_valid_IN,
   input  logic [RENISS_WIDTH-1:0] ren_data_IN,
   output logic                    ren_stall_OUT,
   output logic                    IQ_pushReq_OUT,
   output logic [RENISS_WIDTH-1:0] IQ_pushData_OUT,
   input  logic                    IQ_full_IN,
   output logic                    LSQ_pushReq_OUT,
   output logic [RENISS_WIDTH-1:0] LSQ_pushData_OUT,
   input  logic                    LSQ_full_IN,
   output logic [ADDR_WIDTH:0]     occupancy_OUT,
   output logic [CNT_WIDTH-1:0]    iq_disp_cnt_OUT,
   output logic [CNT_WIDTH-1:0]    lsq_disp_cnt_OUT
);
   logic                    enq, deq, full, empty, go, iq_req, lsq_req;
   logic [RENISS_WIDTH-1:0] head;
   tgt_e                    tgt;
   logic [CNT_WIDTH-1:0]    iq_cnt_q, iq_cnt_d, lsq_cnt_q, lsq_cnt_d;

   ren_dispatch_fifo #(.W(RENISS_WIDTH), .AW(ADDR_WIDTH)) u_fifo (
      .clk       (CLK),
      .rst_n     (RESET),
      .flush     (FLUSH_IN),
      .wr_en     (enq),
      .wr_data   (ren_data_IN),
      .rd_en     (deq),
      .head_data (head),
      .occupancy (occupancy_OUT),
      .full      (full),
      .empty     (empty)
   );

   // Head-of-line blocking: only the head is ever considered, whatever the other queue's state.
   always_comb begin
      tgt       = tgt_sel(head[MEMREAD_BIT], head[MEMWRITE_BIT]);
      go        = !empty && !FREEZE && !FLUSH_IN;
      lsq_req   = go && (tgt == TGT_LSQ) && !LSQ_full_IN;
      iq_req    = go && (tgt == TGT_IQ) && !IQ_full_IN;
      deq       = iq_req || lsq_req;
      enq       = ren_valid_IN && !full && !FREEZE && !FLUSH_IN;
      iq_cnt_d  = iq_cnt_q + {{(CNT_WIDTH-1){1'b0}}, iq_req};
      lsq_cnt_d = lsq_cnt_q + {{(CNT_WIDTH-1){1'b0}}, lsq_req};
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         iq_cnt_q  <= '0;
         lsq_cnt_q <= '0;
      end else begin
         iq_cnt_q  <= iq_cnt_d;
         lsq_cnt_q <= lsq_cnt_d;
      end
   end

   assign ren_stall_OUT    = full;
   assign IQ_pushReq_OUT   = iq_req;
   assign LSQ_pushReq_OUT  = lsq_req;
   assign IQ_pushData_OUT  = iq_req ? head : '0;
   assign LSQ_pushData_OUT = lsq_req ? head : '0;
   assign iq_disp_cnt_OUT  = iq_cnt_q;
   assign lsq_disp_cnt_OUT = lsq_cnt_q;
endmodule

// File: tb/tb_ren_dispatch.sv
// tb_ren_dispatch: queue-based reference model with a scoreboard monitor for ren_dispatch.
module tb_ren_dispatch;
   logic         CLK = 1'b0;
   logic         RESET = 1'b0;
   logic         FREEZE = 1'b0;
   logic         FLUSH_IN = 1'b0;
   logic         ren_valid_IN = 1'b0;
   logic [150:0] ren_data_IN = '0;
   logic         ren_stall_OUT;
   logic         IQ_pushReq_OUT;
   logic [150:0] IQ_pushData_OUT;
   logic         IQ_full_IN = 1'b0;
   logic         LSQ_pushReq_OUT;
   logic [150:0] LSQ_pushData_OUT;
   logic         LSQ_full_IN = 1'b0;
   logic [2:0]   occupancy_OUT;
   logic [15:0]  iq_disp_cnt_OUT;
   logic [15:0]  lsq_disp_cnt_OUT;

   ren_dispatch dut (
      .CLK              (CLK),
      .RESET            (RESET),
      .FREEZE           (FREEZE),
      .FLUSH_IN         (FLUSH_IN),
      .ren_valid_IN     (ren_valid_IN),
      .ren_data_IN      (ren_data_IN),
      .ren_stall_OUT    (ren_stall_OUT),
      .IQ_pushReq_OUT   (IQ_pushReq_OUT),
      .IQ_pushData_OUT  (IQ_pushData_OUT),
      .IQ_full_IN       (IQ_full_IN),
      .LSQ_pushReq_OUT  (LSQ_pushReq_OUT),
      .LSQ_pushData_OUT (LSQ_pushData_OUT),
      .LSQ_full_IN      (LSQ_full_IN),
      .occupancy_OUT    (occupancy_OUT),
      .iq_disp_cnt_OUT  (iq_disp_cnt_OUT),
      .lsq_disp_cnt_OUT (lsq_disp_cnt_OUT)
   );

   always #5 CLK = ~CLK;

   // Reference model: buffer contents as a plain queue plus dispatch totals.
   logic [150:0] mq[$];
   logic [150:0] exp_q[$];
   bit           exp_tq[$];
   int           exp_occ, n_chk, n_fail;
   bit           exp_stall, exp_push, last_acc, chk_en;
   logic [15:0]  exp_iq_cnt, exp_lsq_cnt;

   function automatic bit is_mem(input logic [150:0] w);
      return w[39] | w[40];
   endfunction

   function automatic logic [150:0] mk(input logic [1:0] t);
      logic [159:0] r;
      logic [150:0] w;
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      w = r[150:0];
      w[40:39] = t;
      return w;
   endfunction

   task automatic chk(input string name, input logic [150:0] act, input logic [150:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic cyc(input bit v, input logic [150:0] d, input bit iqf, input bit lsqf,
                      input bit frz, input bit fl);
      bit acc;
      @(negedge CLK);
      RESET = 1'b1;
      ren_valid_IN = v;
      ren_data_IN = d;
      IQ_full_IN = iqf;
      LSQ_full_IN = lsqf;
      FREEZE = frz;
      FLUSH_IN = fl;
      exp_occ = mq.size();
      exp_stall = (mq.size() == 4);
      exp_push = mq.size() > 0 && !frz && !fl && (is_mem(mq[0]) ? !lsqf : !iqf);
      if (exp_push) begin
         exp_q.push_back(mq[0]);
         exp_tq.push_back(is_mem(mq[0]));
      end
      acc = v && mq.size() < 4 && !frz && !fl;
      chk_en = 1'b1;
      @(posedge CLK);
      if (fl) mq.delete();
      else begin
         if (exp_push) begin
            if (is_mem(mq[0])) exp_lsq_cnt++;
            else exp_iq_cnt++;
            void'(mq.pop_front());
         end
         if (acc) mq.push_back(d);
      end
      last_acc = acc;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      chk_en = 1'b0;
      RESET = 1'b0;
      ren_valid_IN = 1'b0;
      FREEZE = 1'b0;
      FLUSH_IN = 1'b0;
      repeat (2) @(posedge CLK);
      mq.delete();
      exp_q.delete();
      exp_tq.delete();
      exp_iq_cnt = '0;
      exp_lsq_cnt = '0;
   endtask

   // Monitor: compares registered state every cycle and pops the scoreboard on each push.
   initial forever begin
      @(negedge CLK);
      #1;
      if (chk_en) begin
         chk("occupancy", 151'(occupancy_OUT), 151'(exp_occ));
         chk("stall", 151'(ren_stall_OUT), 151'(exp_stall));
         chk("iq_cnt", 151'(iq_disp_cnt_OUT), 151'(exp_iq_cnt));
         chk("lsq_cnt", 151'(lsq_disp_cnt_OUT), 151'(exp_lsq_cnt));
         chk("push_req", 151'(IQ_pushReq_OUT | LSQ_pushReq_OUT), 151'(exp_push));
         chk("push_onehot", 151'(IQ_pushReq_OUT & LSQ_pushReq_OUT), 151'(0));
         if (!IQ_pushReq_OUT) chk("iq_data_idle", IQ_pushData_OUT, '0);
         if (!LSQ_pushReq_OUT) chk("lsq_data_idle", LSQ_pushData_OUT, '0);
         if (IQ_pushReq_OUT || LSQ_pushReq_OUT) begin
            chk("sb_has_entry", 151'(exp_q.size() > 0), 151'(1));
            if (exp_q.size() > 0) begin
               chk("push_target", 151'(LSQ_pushReq_OUT), 151'(exp_tq.pop_front()));
               chk("push_data", LSQ_pushReq_OUT ? LSQ_pushData_OUT : IQ_pushData_OUT,
                   exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [150:0] w[6];
      n_chk = 0;
      n_fail = 0;
      do_reset();
      repeat (2) cyc(0, '0, 0, 0, 0, 0);
      // steering: ALU, load, store
      cyc(1, mk(2'b00), 0, 0, 0, 0);
      cyc(1, mk(2'b01), 0, 0, 0, 0);
      cyc(1, mk(2'b10), 0, 0, 0, 0);
      repeat (2) cyc(0, '0, 0, 0, 0, 0);
      chk("steer_iq_total", 151'(iq_disp_cnt_OUT), 151'(1));
      chk("steer_lsq_total", 151'(lsq_disp_cnt_OUT), 151'(2));
      // head-of-line blocking
      cyc(1, mk(2'b01), 0, 1, 0, 0);
      cyc(1, mk(2'b00), 0, 1, 0, 0);
      repeat (5) cyc(0, '0, 0, 1, 0, 0);
      repeat (3) cyc(0, '0, 0, 0, 0, 0);
      // fill, refuse the fifth, then hold it until accepted
      for (int i = 0; i < 5; i++) begin
         w[i] = mk(2'($urandom_range(0, 3)));
         cyc(1, w[i], 1, 1, 0, 0);
      end
      chk("fill_stall", 151'(ren_stall_OUT), 151'(1));
      for (int i = 0; i < 10; i++) begin
         cyc(1, w[4], 0, 0, 0, 0);
         if (last_acc) break;
      end
      chk("fifth_accepted", 151'(last_acc), 151'(1));
      repeat (6) cyc(0, '0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) cyc(1, mk(2'($urandom_range(0, 3))), 0, 0, 0, 0);
      repeat (3) cyc(0, '0, 0, 0, 0, 0);
      // flush with enqueue and dispatch pending
      for (int i = 0; i < 3; i++) cyc(1, mk(2'($urandom_range(0, 3))), 1, 1, 0, 0);
      cyc(1, mk(2'b00), 0, 0, 0, 1);
      repeat (2) cyc(0, '0, 0, 0, 0, 0);
      // freeze at occupancy 2
      for (int i = 0; i < 2; i++) cyc(1, mk(2'($urandom_range(0, 3))), 1, 1, 0, 0);
      repeat (3) cyc(1, mk(2'b00), 0, 0, 1, 0);
      repeat (3) cyc(0, '0, 0, 0, 0, 0);
      // randomized traffic with one mid-run reset
      for (int i = 0; i < 1500; i++) begin
         bit fl, frz;
         if (i == 700) do_reset();
         fl = $urandom_range(0, 99) < 3;
         frz = !fl && $urandom_range(0, 9) == 0;
         cyc($urandom_range(0, 9) < 6, mk(2'($urandom_range(0, 3))),
             $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, frz, fl);
      end
      repeat (8) cyc(0, '0, 0, 0, 0, 0);
      @(negedge CLK);
      #3;
      chk("sb_drained", 151'(exp_q.size()), 151'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
